branch_flag_unit: RTL
=====================

// Module: branch_flag_unit
// PURPOSE
//   EX-stage consumer of the decoded control bundle. Holds the N/Z/V flag register,
//   resolves B/BR branches against the registered flags, and issues a one-cycle
//   PC redirect + flush to fetch/decode. Sequences HLT: drains older instructions,
//   then asserts a sticky halted output. Sits between the ID/EX register and the PC mux.
// PARAMETERS
//   DATA_W        16  datapath / PC width
//   OFFSET_W       9  B-type signed word-offset width
//   DRAIN_CYCLES   2  cycles spent in DRAIN after HLT before halted (MEM+WB)
// PORTS
//   clk          in   1        clock, rising edge
//   rst          in   1        synchronous reset, active-high
//   stall        in   1        pipeline freeze; every register holds its value
//   ex_valid     in   1        EX holds a real instruction
//   ex_opcode    in   4        opcode of the EX instruction
//   ex_B         in   1        B decoded (PC-relative branch)
//   ex_BR        in   1        BR decoded (register branch)
//   ex_HLT       in   1        HLT decoded
//   ex_cond      in   3        branch condition field ccc
//   ex_imm       in   OFFSET_W signed word offset (B only)
//   ex_rs_data   in   DATA_W   BR target register value
//   ex_pc_plus2  in   DATA_W   PC of EX instruction + 2
//   alu_result   in   DATA_W   ALU result of EX instruction
//   alu_ovf      in   1        ALU signed overflow (ADD/SUB)
//   flags        out  3        registered {N,Z,V}
//   redirect     out  1        taken-branch pulse to PC mux
//   redirect_pc  out  DATA_W   branch target, valid while redirect=1
//   flush        out  1        squash IF/ID; equals redirect
//   halted       out  1        sticky; processor stopped
// BEHAVIOUR
//   Reset (sync, rst=1 at clk edge): flags=000, redirect=0, flush=0, redirect_pc=0,
//     halted=0, state=RUN, drain counter=0.
//   accept = ex_valid & ~stall & state==RUN & ~redirect (wrong-path slot is ignored).
//   Flag update on accept (written at next edge):
//     ADD(0000), SUB(0001): Z=(alu_result==0), N=alu_result[DATA_W-1], V=alu_ovf.
//     XOR(0010), SLL(0100), SRA(0101), ROR(0110): Z only; N, V keep their value.
//     All other opcodes: no change.
//   Branch resolution on accept & (ex_B|ex_BR), using registered flags:
//     000 NE Z=0 | 001 EQ Z=1 | 010 GT Z=0&N=0 | 011 LT N=1
//     100 GE Z=1|(Z=0&N=0) | 101 LE N=1|Z=1 | 110 OV V=1 | 111 always.
//   Target: B  -> ex_pc_plus2 + (sext(ex_imm) << 1), modulo 2^DATA_W (wraps).
//           BR -> ex_rs_data.
//   Latency: taken branch in EX at cycle t -> redirect=flush=1 and redirect_pc
//     valid in cycle t+1 only. Not taken -> no pulse.
//   The EX instruction in cycle t+1 (redirect=1) is wrong-path: no flag update,
//     no branch, no HLT.
//   stall=1 while redirect=1: redirect, flush and redirect_pc hold; they drop in the
//     cycle after the first non-stalled cycle.
//   HLT FSM: RUN -> DRAIN on accept & ex_HLT; counter loads DRAIN_CYCLES-1.
//     DRAIN: decrements each non-stalled cycle; at 0 -> HALTED.
//     HALTED: halted=1; only rst leaves it.
//     DRAIN and HALTED ignore all ex_* inputs.
//   HLT and branch flags are never both set (decoder guarantee). rst in DRAIN/HALTED
//     returns to RUN in the next cycle.
// STRUCTURE
//   Shared package cpu_pkg: opcode constants OP_ADD..OP_HLT, condition codes
//     CC_NE..CC_UNC, flag bit indices FLG_N/FLG_Z/FLG_V, HLT FSM state encoding.
//   One combinational sub-module: branch_cond_eval (cond + flags -> taken).
//   Target adder and FSM stay in this module.
// TESTING
//   1 SUB result 0x0000, then B EQ imm=+4, pc_plus2=0x0010
//     -> flags Z=1; next cycle redirect=flush=1, redirect_pc=0x0018, for one cycle.
//   2 ADD result 0x8000 ovf=1 (N=1, V=1), then XOR result 0x0001
//     -> flags N=1 Z=0 V=1; B LT is taken, B OV is taken.
//   3 B GT imm=0x1FF (-1), pc_plus2=0x0004, flags Z=0 N=0 -> redirect_pc=0x0002.
//     Then pc_plus2=0x0000, imm=-1 -> 0xFFFE (wrap).
//   4 BR ccc=111, rs=0x1234; ADD result 0 in the next (redirect) cycle
//     -> redirect_pc=0x1234; flags unchanged; no second redirect.
//   5 HLT at cycle t, DRAIN_CYCLES=2 -> halted=1 from t+3; later ADD and B do nothing.
//     Repeat with rst at t+2 -> RUN, halted stays 0.
//   6 Taken branch, stall=1 for 3 cycles -> redirect and redirect_pc held 4 cycles,
//     then low.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, branch condition codes, flag bit positions
// and the HLT sequencing state encoding.
package cpu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_RED = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1001;
  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [2:0] CC_NE  = 3'b000;
  localparam logic [2:0] CC_EQ  = 3'b001;
  localparam logic [2:0] CC_GT  = 3'b010;
  localparam logic [2:0] CC_LT  = 3'b011;
  localparam logic [2:0] CC_GE  = 3'b100;
  localparam logic [2:0] CC_LE  = 3'b101;
  localparam logic [2:0] CC_OV  = 3'b110;
  localparam logic [2:0] CC_UNC = 3'b111;

  // Flag vector is packed {N,Z,V}.
  localparam int FLG_N = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_V = 0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } hlt_state_t;

endpackage

// File: rtl/branch_flag_unit_if.sv
// EX-stage control/data bundle into the branch/flag unit and its redirect/status outputs.
interface branch_flag_unit_if #(
  parameter int DATA_W   = 16,
  parameter int OFFSET_W = 9
);
  logic                stall;
  logic                ex_valid;
  logic [3:0]          ex_opcode;
  logic                ex_B;
  logic                ex_BR;
  logic                ex_HLT;
  logic [2:0]          ex_cond;
  logic [OFFSET_W-1:0] ex_imm;
  logic [DATA_W-1:0]   ex_rs_data;
  logic [DATA_W-1:0]   ex_pc_plus2;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_ovf;
  logic [2:0]          flags;
  logic                redirect;
  logic [DATA_W-1:0]   redirect_pc;
  logic                flush;
  logic                halted;

  modport master (
    output stall, ex_valid, ex_opcode, ex_B, ex_BR, ex_HLT, ex_cond, ex_imm,
           ex_rs_data, ex_pc_plus2, alu_result, alu_ovf,
    input  flags, redirect, redirect_pc, flush, halted
  );

  modport slave (
    input  stall, ex_valid, ex_opcode, ex_B, ex_BR, ex_HLT, ex_cond, ex_imm,
           ex_rs_data, ex_pc_plus2, alu_result, alu_ovf,
    output flags, redirect, redirect_pc, flush, halted
  );
endinterface

// File: rtl/branch_cond_eval.sv
// Combinational branch condition check of a 3-bit ccc field against {N,Z,V}.
module branch_cond_eval
  import cpu_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       taken
);

  logic n, z, v;

  always_comb begin
    n     = flags[FLG_N];
    z     = flags[FLG_Z];
    v     = flags[FLG_V];
    taken = 1'b0;
    case (cond)
      CC_NE:   taken = ~z;
      CC_EQ:   taken = z;
      CC_GT:   taken = ~z & ~n;
      CC_LT:   taken = n;
      CC_GE:   taken = z | (~z & ~n);
      CC_LE:   taken = n | z;
      CC_OV:   taken = v;
      CC_UNC:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_flag_unit.sv
// EX-stage flag register, branch resolution with one-cycle PC redirect/flush,
// and HLT drain sequencing into a sticky halted state.
module branch_flag_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int OFFSET_W     = 9,
  parameter int DRAIN_CYCLES = 2
) (
  input logic             clk,
  input logic             rst,
  branch_flag_unit_if.slave bus
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  function automatic logic [DATA_W-1:0] b_target(
    input logic        [DATA_W-1:0]   pc,
    input logic signed [OFFSET_W-1:0] imm
  );
    logic signed [DATA_W-1:0] off;
    off = {{(DATA_W-OFFSET_W){imm[OFFSET_W-1]}}, imm};
    return pc + ($unsigned(off) << 1);
  endfunction

  logic [2:0]        flags_p1;
  logic              redirect_p1;
  logic [DATA_W-1:0] redirect_pc_p1;
  hlt_state_t        state_p1;
  logic [CNT_W-1:0]  cnt_p1;

  logic [2:0]        flags_d;
  hlt_state_t        state_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              accept;
  logic              cond_true;
  logic              take;
  logic [DATA_W-1:0] target;

  // ---- stage p0: decode-side combinational resolution ----
  // The slot right after a redirect is wrong-path and must not commit anything.
  assign accept = bus.ex_valid & ~bus.stall & (state_p1 == ST_RUN) & ~redirect_p1;

  branch_cond_eval u_cond (
    .cond  (bus.ex_cond),
    .flags (flags_p1),
    .taken (cond_true)
  );

  assign take   = accept & (bus.ex_B | bus.ex_BR) & cond_true;
  assign target = bus.ex_BR ? bus.ex_rs_data : b_target(bus.ex_pc_plus2, bus.ex_imm);

  always_comb begin
    flags_d = flags_p1;
    if (accept) begin
      case (bus.ex_opcode)
        OP_ADD, OP_SUB: begin
          flags_d[FLG_N] = bus.alu_result[DATA_W-1];
          flags_d[FLG_Z] = (bus.alu_result == '0);
          flags_d[FLG_V] = bus.alu_ovf;
        end
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags_d[FLG_Z] = (bus.alu_result == '0);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_p1;
    cnt_d   = cnt_p1;
    if (!bus.stall) begin
      case (state_p1)
        ST_RUN: begin
          if (accept && bus.ex_HLT) begin
            state_d = ST_DRAIN;
            cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
          end
        end
        ST_DRAIN: begin
          if (cnt_p1 == '0) state_d = ST_HALTED;
          else              cnt_d   = cnt_p1 - CNT_W'(1);
        end
        ST_HALTED: ;
        default: state_d = ST_RUN;
      endcase
    end
  end

  // ---- stage p1: registered flags, redirect pulse and HLT state ----
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_p1       <= '0;
      redirect_p1    <= 1'b0;
      redirect_pc_p1 <= '0;
      state_p1       <= ST_RUN;
      cnt_p1         <= '0;
    end else if (!bus.stall) begin
      flags_p1    <= flags_d;
      redirect_p1 <= take;
      if (take) redirect_pc_p1 <= target;
      state_p1    <= state_d;
      cnt_p1      <= cnt_d;
    end
  end

  assign bus.flags       = flags_p1;
  assign bus.redirect    = redirect_p1;
  assign bus.flush       = redirect_p1;
  assign bus.redirect_pc = redirect_pc_p1;
  assign bus.halted      = (state_p1 == ST_HALTED);

endmodule
